// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield: game states,
// round-winner encodings and the centre-LED computation.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        ROUND_WON  = 2'd1,
        MATCH_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10
    } winner_t;

    // The rope starts on the middle LED of an odd-width playfield.
    function automatic int center(input int numLeds);
        return (numLeds - 1) / 2;
    endfunction

endpackage

// File: rtl/score_counter.sv
// Saturating 3-bit round-win counter; counts inc pulses and stops at limit.
module score_counter
    import tug_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       inc,
    input  logic [2:0] limit,
    output logic [2:0] count
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= 3'd0;
        end else if (inc && (count < limit)) begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/tug_playfield.sv
// Two-player tug-of-war: L/R presses pull a lit LED across the playfield,
// pushing past an edge wins the round; first to WIN_SCORE rounds wins the match.
module tug_playfield
    import tug_pkg::*;
#(
    parameter int NUM_LEDS    = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                L,
    input  logic                R,
    output logic [NUM_LEDS-1:0] LEDR,
    output logic [1:0]          winner,
    output logic [2:0]          scoreL,
    output logic [2:0]          scoreR,
    output logic                match_over
);

    localparam int PW = $clog2(NUM_LEDS);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [PW-1:0] CENTER     = PW'(center(NUM_LEDS));
    localparam logic [PW-1:0] LAST_POS   = PW'(NUM_LEDS - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    SCORE_MAX  = 3'(WIN_SCORE);
    localparam logic [2:0]    SCORE_LAST = 3'(WIN_SCORE - 1);

    state_t        state, stateNext;
    winner_t       winnerReg, winnerNext;
    logic [PW-1:0] pos, posNext;
    logic [HW-1:0] holdCnt, holdNext;
    logic          incL, incR;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= PLAY;
            pos       <= CENTER;
            holdCnt   <= '0;
            winnerReg <= NONE;
        end else begin
            state     <= stateNext;
            pos       <= posNext;
            holdCnt   <= holdNext;
            winnerReg <= winnerNext;
        end
    end

    // A round win goes straight to MATCH_DONE when it is the deciding one,
    // so the final board never flashes the round-win blank display.
    always_comb begin
        stateNext  = state;
        posNext    = pos;
        holdNext   = holdCnt;
        winnerNext = winnerReg;
        incL       = 1'b0;
        incR       = 1'b0;
        case (state)
            PLAY: begin
                winnerNext = NONE;
                if (L && !R) begin
                    if (pos == LAST_POS) begin
                        incL       = 1'b1;
                        winnerNext = LEFT;
                        if (scoreL == SCORE_LAST) begin
                            stateNext = MATCH_DONE;
                        end else begin
                            stateNext = ROUND_WON;
                            holdNext  = HOLD_LOAD;
                        end
                    end else begin
                        posNext = pos + 1'b1;
                    end
                end else if (R && !L) begin
                    if (pos == '0) begin
                        incR       = 1'b1;
                        winnerNext = RIGHT;
                        if (scoreR == SCORE_LAST) begin
                            stateNext = MATCH_DONE;
                        end else begin
                            stateNext = ROUND_WON;
                            holdNext  = HOLD_LOAD;
                        end
                    end else begin
                        posNext = pos - 1'b1;
                    end
                end
            end
            ROUND_WON: begin
                if (holdCnt == '0) begin
                    stateNext  = PLAY;
                    posNext    = CENTER;
                    winnerNext = NONE;
                end else begin
                    holdNext = holdCnt - 1'b1;
                end
            end
            MATCH_DONE: begin
                stateNext = MATCH_DONE;
            end
            default: begin
                stateNext = PLAY;
                posNext   = CENTER;
            end
        endcase
    end

    always_comb begin
        LEDR = '0;
        case (state)
            PLAY:       LEDR = NUM_LEDS'(1) << pos;
            MATCH_DONE: LEDR = '1;
            default:    LEDR = '0;
        endcase
    end

    assign winner     = winnerReg;
    assign match_over = (state == MATCH_DONE);

    score_counter uScoreL (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (incL),
        .limit (SCORE_MAX),
        .count (scoreL)
    );

    score_counter uScoreR (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (incR),
        .limit (SCORE_MAX),
        .count (scoreR)
    );

endmodule

// File: tb/tb_tug_playfield.sv
// Directed self-checking bench for tug_playfield with default parameters.
module tb_tug_playfield;

    logic       Clock;
    logic       Reset;
    logic       L;
    logic       R;
    logic [8:0] LEDR;
    logic [1:0] winner;
    logic [2:0] scoreL;
    logic [2:0] scoreR;
    logic       match_over;

    int checks   = 0;
    int failures = 0;

    tug_playfield #(
        .NUM_LEDS    (9),
        .WIN_SCORE   (7),
        .HOLD_CYCLES (4)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .L          (L),
        .R          (R),
        .LEDR       (LEDR),
        .winner     (winner),
        .scoreL     (scoreL),
        .scoreR     (scoreR),
        .match_over (match_over)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Drive one cycle of presses, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic l, input logic r);
        L = l;
        R = r;
        @(posedge Clock);
        #1;
        L = 1'b0;
        R = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [8:0] eLed,
                            input logic [1:0] eWin, input logic [2:0] eL,
                            input logic [2:0] eR, input logic eOver);
        checkOutput({tag, ".LEDR"}, 32'(LEDR), 32'(eLed));
        checkOutput({tag, ".winner"}, 32'(winner), 32'(eWin));
        checkOutput({tag, ".scoreL"}, 32'(scoreL), 32'(eL));
        checkOutput({tag, ".scoreR"}, 32'(scoreR), 32'(eR));
        checkOutput({tag, ".match_over"}, 32'(match_over), 32'(eOver));
    endtask

    initial begin
        L     = 1'b0;
        R     = 1'b0;
        Reset = 1'b1;
        #2;
        checkAll("reset", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        repeat (4) applyStimulus(1'b1, 1'b0);
        checkAll("leftEdge", 9'b100000000, 2'b00, 3'd0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkAll("leftWin1", 9'b000000000, 2'b10, 3'd1, 3'd0, 1'b0);

        repeat (3) applyStimulus(1'b1, 1'b0);
        checkAll("holdIgnoreL", 9'b000000000, 2'b10, 3'd1, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkAll("holdExit", 9'b000010000, 2'b00, 3'd1, 3'd0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("cancel.LEDR", 32'(LEDR), 32'(9'b000010000));
        end

        repeat (4) applyStimulus(1'b0, 1'b1);
        checkAll("rightEdge", 9'b000000001, 2'b00, 3'd1, 3'd0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkAll("edgeNoWin", 9'b000000001, 2'b00, 3'd1, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkAll("rightWin1", 9'b000000000, 2'b01, 3'd1, 3'd1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkAll("rightHoldExit", 9'b000010000, 2'b00, 3'd1, 3'd1, 1'b0);

        for (int w = 2; w <= 6; w++) begin
            repeat (5) applyStimulus(1'b1, 1'b0);
            checkOutput("leftWinN.scoreL", 32'(scoreL), 32'(w));
            checkOutput("leftWinN.winner", 32'(winner), 32'(2'b10));
            repeat (4) applyStimulus(1'b0, 1'b0);
            checkOutput("leftWinN.center", 32'(LEDR), 32'(9'b000010000));
        end

        repeat (5) applyStimulus(1'b1, 1'b0);
        checkAll("matchDone", 9'b111111111, 2'b10, 3'd7, 3'd1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b0);
        checkAll("matchFrozen", 9'b111111111, 2'b10, 3'd7, 3'd1, 1'b1);

        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checkAll("resetFromMatch", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        for (int w = 1; w <= 3; w++) begin
            repeat (5) applyStimulus(1'b1, 1'b0);
            if (w < 3) repeat (4) applyStimulus(1'b0, 1'b0);
        end
        checkAll("roundWon3", 9'b000000000, 2'b10, 3'd3, 3'd0, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        checkAll("asyncResetRoundWon", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkAll("firstEdgeAfterReset", 9'b000100000, 2'b00, 3'd0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tug_playfield.md
TUG_PLAYFIELD -- requirements
Module: tug_playfield

Interface
REQ-001 Parameter: NUM_LEDS, 9, playfield width in LEDs (odd, >= 3).
REQ-002 Parameter: WIN_SCORE, 7, round wins that end the match (1..7).
REQ-003 Parameter: HOLD_CYCLES, 4, cycles the round-win display is held before the next serve (>= 1).
REQ-004 Port: Clock, input, 1, sole clock, all state on posedge.
REQ-005 Port: Reset, input, 1, asynchronous active-high reset.
REQ-006 Port: L, input, 1, left-player press, one-cycle pulse from the key-press conditioning stage.
REQ-007 Port: R, input, 1, right-player press, one-cycle pulse from the key-press conditioning stage.
REQ-008 Port: LEDR, output, NUM_LEDS, playfield; bit NUM_LEDS-1 is the leftmost LED, bit 0 the rightmost.
REQ-009 Port: winner, output, 2, 00 none, 10 left won last round, 01 right won last round.
REQ-010 Port: scoreL, output, 3, left round-win count.
REQ-011 Port: scoreR, output, 3, right round-win count.
REQ-012 Port: match_over, output, 1, high once either score equals WIN_SCORE.

Function
REQ-013 States: PLAY, ROUND_WON, MATCH_DONE.
REQ-014 pos, 0..NUM_LEDS-1, registered; CENTER = (NUM_LEDS-1)/2.
REQ-015 PLAY: LEDR one-hot at pos; winner = 00.
REQ-016 PLAY, L=1 and R=0, pos < NUM_LEDS-1: pos+1 at next edge.
REQ-017 PLAY, R=1 and L=0, pos > 0: pos-1 at next edge.
REQ-018 PLAY, L=R=1 or L=R=0: pos holds (simultaneous presses cancel).
REQ-019 PLAY, pos = NUM_LEDS-1 and L=1, R=0: left wins the round; next edge -> ROUND_WON, winner=10, scoreL+1.
REQ-020 PLAY, pos = 0 and R=1, L=0: right wins the round; next edge -> ROUND_WON, winner=01, scoreR+1.
REQ-021 Reaching an edge LED is not a win; a further press past the edge is required.
REQ-022 ROUND_WON: LEDR all zeros; winner held; L/R ignored; hold counter loads HOLD_CYCLES-1 on entry.
REQ-023 ROUND_WON: after exactly HOLD_CYCLES cycles -> PLAY, pos = CENTER, winner = 00.
REQ-024 Round win that brings a score to WIN_SCORE: next edge -> MATCH_DONE, not ROUND_WON.
REQ-025 MATCH_DONE: LEDR all ones; winner held; match_over=1; scores frozen; L/R ignored; exit only by Reset.
REQ-026 Scores never exceed WIN_SCORE; no wrap-around.
REQ-027 All outputs registered or decoded from registered state only; latency from L/R edge sample to LEDR change is one clock.

Reset
REQ-028 Reset asserted: immediately (asynchronously) state=PLAY, pos=CENTER, scores=0, winner=00, match_over=0, hold counter=0.
REQ-029 Reset mid-round, during ROUND_WON, or in MATCH_DONE: same values as REQ-028; no partial score retained.
REQ-030 First active edge after Reset deassertion samples L/R normally.

Structure
REQ-031 Package tug_pkg: state enum, winner encodings (NONE, LEFT, RIGHT), and the CENTER computation function.
REQ-032 Sub-module score_counter (saturating 3-bit counter with inc and limit inputs), instantiated once per player.

Verification
REQ-033 Reset, then 4 L pulses -> LEDR = 9'b100000000; 5th L pulse -> LEDR=0, winner=10, scoreL=1; after 4 cycles LEDR=9'b000010000.
REQ-034 From center, L and R high in the same cycle for 3 cycles -> LEDR stays 9'b000010000.
REQ-035 4 R pulses (pos 0), then 3 idle cycles -> no win, LEDR=9'b000000001; 1 R pulse -> winner=01, scoreR=1.
REQ-036 Left wins 7 rounds -> after 7th win match_over=1, LEDR all ones, scoreL=7; further L/R pulses change nothing.
REQ-037 L pulses during ROUND_WON hold -> ignored; next round starts at CENTER.
REQ-038 Reset asserted between clock edges in ROUND_WON with scoreL=3 -> outputs return to REQ-028 values before the next edge.
